// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit.
// Optional SHIFT_EARLY_EXIT_EN macro is consumed by iter_shift_unit.
package shift_pkg;

    // Default datapath geometry
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_SHAMT_WIDTH = 5;

    // Shift opcodes; 2'b11 is reserved and behaves as sll
    localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
    localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
    localparam logic [1:0] SHIFT_OP_SRA = 2'b10;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_one_step.sv
// Combinational one-bit shift step used by the iterative shifter.
// Reserved opcode falls through to the sll path.
module shift_one_step
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    // Select fill bit and direction from the opcode
    always_comb begin
        dout = {din[DATA_WIDTH-2:0], 1'b0};
        unique case (1'b1)
            (op == SHIFT_OP_SRL): dout = {1'b0, din[DATA_WIDTH-1:1]};
            (op == SHIFT_OP_SRA): dout = {din[DATA_WIDTH-1], din[DATA_WIDTH-1:1]};
            default:              dout = {din[DATA_WIDTH-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Iterative one-bit-per-clock shifter with registered result and ready pulse.
// Define SHIFT_EARLY_EXIT_EN to finish as soon as further steps cannot change the value.
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SHAMT_WIDTH = DEF_SHAMT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ctrl_start,
    input  logic [1:0]             ctrl_op,
    input  logic [DATA_WIDTH-1:0]  data_operandA,
    input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
    output logic [DATA_WIDTH-1:0]  data_result,
    output logic                   data_resultRDY,
    output logic                   data_busy
);

    state_t                 state;
    state_t                 state_n;
    logic [DATA_WIDTH-1:0]  work;
    logic [DATA_WIDTH-1:0]  work_n;
    logic [DATA_WIDTH-1:0]  step_out;
    logic [DATA_WIDTH-1:0]  result_n;
    logic [SHAMT_WIDTH-1:0] count;
    logic [SHAMT_WIDTH-1:0] count_n;
    logic [1:0]             op;
    logic [1:0]             op_n;
    logic                   settled;

    shift_one_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .op   (op),
        .din  (work),
        .dout (step_out)
    );

`ifdef SHIFT_EARLY_EXIT_EN
    // Value is a fixed point of the step: all zero, or all sign bits for sra
    always_comb begin
        settled = (work == '0);
        if (op == SHIFT_OP_SRA) begin
            settled = (work == {DATA_WIDTH{work[DATA_WIDTH-1]}});
        end
    end
`else
    // Always run the full shift count
    always_comb begin
        settled = 1'b0;
    end
`endif

    // Next-state and datapath update
    always_comb begin
        state_n  = state;
        work_n   = work;
        count_n  = count;
        op_n     = op;
        result_n = data_result;
        unique case (1'b1)
            (state == ST_SHIFT): begin
                if (count == '0 || settled) begin
                    result_n = work;
                    state_n  = ST_DONE;
                end else begin
                    work_n  = step_out;
                    count_n = count - SHAMT_WIDTH'(1);
                end
            end
            (state == ST_IDLE),
            (state == ST_DONE): begin
                if (ctrl_start) begin
                    work_n  = data_operandA;
                    count_n = ctrl_shiftamt;
                    op_n    = ctrl_op;
                    state_n = ST_SHIFT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            work           <= '0;
            count          <= '0;
            op             <= SHIFT_OP_SLL;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            data_busy      <= 1'b0;
        end else begin
            state          <= state_n;
            work           <= work_n;
            count          <= count_n;
            op             <= op_n;
            data_result    <= result_n;
            data_resultRDY <= (state_n == ST_DONE);
            data_busy      <= (state_n == ST_SHIFT);
        end
    end

endmodule
